// File: rtl/sync_counter_n.sv
// sync_counter_n: synchronous modulo-N up/down counter with clock enable,
// clear, parallel load (clamped to MODULUS-1) and a cascadable terminal
// count output.
//
// Optional feature macro: SYNC_COUNTER_MATCH_EN
//   When defined, adds a comparator input and a registered match flag.
//
// Parameters
//   WIDTH   : counter width in bits (1..32)
//   MODULUS : number of count states, 0..MODULUS-1 (2..2**WIDTH)
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset, highest priority
//   ce     in   clock enable; with ce=0 only reset changes state
//   clr_n  in   synchronous clear, active-low
//   load_n in   synchronous parallel load, active-low
//   enp    in   count enable (parallel)
//   ent    in   count enable (trickle), also gates tco
//   up     in   direction, 1 = increment, 0 = decrement
//   p      in   parallel load data
//   q      out  current count
//   tco    out  terminal count (combinational)
//   cmp    in   compare value            (SYNC_COUNTER_MATCH_EN only)
//   match  out  registered q==cmp flag   (SYNC_COUNTER_MATCH_EN only)

module sync_counter_n #(
  parameter int unsigned      WIDTH   = 4,
  parameter longint unsigned  MODULUS = 64'(1) << WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic             clr_n,
  input  logic             load_n,
  input  logic             enp,
  input  logic             ent,
  input  logic             up,
  input  logic [WIDTH-1:0] p,
`ifdef SYNC_COUNTER_MATCH_EN
  input  logic [WIDTH-1:0] cmp,
  output logic             match,
`endif
  output logic [WIDTH-1:0] q,
  output logic             tco
);

  // All arithmetic runs at WIDTH+1 bits so MODULUS = 2**WIDTH wraps cleanly.
  localparam longint unsigned MaxL   = MODULUS - 1;
  localparam logic [WIDTH:0]  MaxVal = MaxL[WIDTH:0];
  localparam logic [WIDTH:0]  One    = {{WIDTH{1'b0}}, 1'b1};

  // The extra MSB of the state is always zero; it keeps the compare and
  // wrap logic at the full arithmetic width.
  logic [WIDTH:0] q_q, q_d;
  logic [WIDTH:0] p_ext, load_ext, up_ext, dn_ext;

  always_comb begin
    p_ext    = {1'b0, p};
    load_ext = (p_ext > MaxVal) ? MaxVal : p_ext;
    up_ext   = (q_q == MaxVal) ? '0 : q_q + One;
    dn_ext   = (q_q == '0) ? MaxVal : q_q - One;

    q_d = q_q;
    if (ce) begin
      if (!clr_n) begin
        q_d = '0;
      end else if (!load_n) begin
        q_d = load_ext;
      end else if (enp && ent) begin
        q_d = up ? up_ext : dn_ext;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q   = q_q[WIDTH-1:0];
  assign tco = ent & (up ? (q_q == MaxVal) : (q_q == '0));

`ifdef SYNC_COUNTER_MATCH_EN
  logic match_q, match_d;

  // Flag reflects the value left by the most recent edge; any edge with ce=0
  // also drops it so it is only ever high for one cycle after a ce edge.
  always_comb begin
    match_d = ce && (q_d == {1'b0, cmp});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      match_q <= 1'b0;
    end else begin
      match_q <= match_d;
    end
  end

  assign match = match_q;
`endif

endmodule

// File: doc/sync_counter_n.md
SYNC_COUNTER_N -- requirements
Module: sync_counter_n

Interface
REQ-001 SHALL have parameter WIDTH, default 4: counter width in bits, legal range 1..32.
REQ-002 SHALL have parameter MODULUS, default 2**WIDTH: count states 0..MODULUS-1, legal range 2..2**WIDTH.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-005 SHALL have port ce, input, 1 bit: clock-enable pulse; no state change except reset when low.
REQ-006 SHALL have port clr_n, input, 1 bit: synchronous clear, active-low.
REQ-007 SHALL have port load_n, input, 1 bit: synchronous parallel load, active-low.
REQ-008 SHALL have port enp, input, 1 bit: count enable, parallel.
REQ-009 SHALL have port ent, input, 1 bit: count enable, trickle; also gates tco.
REQ-010 SHALL have port up, input, 1 bit: direction, 1 = increment, 0 = decrement.
REQ-011 SHALL have port p, input, WIDTH bits: parallel load data.
REQ-012 SHALL have port q, output, WIDTH bits: current count, driven directly from the state register.
REQ-013 SHALL have port tco, output, 1 bit: terminal count, combinational.

Function
REQ-014 Action priority at a clk edge with ce=1 SHALL be clr_n=0, then load_n=0, then enp=1 and ent=1 (count), else hold.
REQ-015 Clear SHALL set q to 0 regardless of load_n, enp, ent and up.
REQ-016 Load SHALL set q to p when p < MODULUS, and to MODULUS-1 when p >= MODULUS (clamp).
REQ-017 Count up SHALL set q to q+1, wrapping from MODULUS-1 to 0.
REQ-018 Count down SHALL set q to q-1, wrapping from 0 to MODULUS-1.
REQ-019 Arithmetic SHALL be carried out at WIDTH+1 bits so that MODULUS=2**WIDTH wraps correctly; no out-of-range value SHALL ever be stored.
REQ-020 Each counting edge SHALL change q by exactly one step; latency from an enabled edge to a new q SHALL be zero cycles after the edge.
REQ-021 tco SHALL equal ent AND (q==MODULUS-1 when up=1, else q==0), independent of ce, enp, clr_n and load_n.
REQ-022 Chaining tco into the next stage's ent, with shared clk, ce and enp, SHALL yield a synchronous cascade with no extra cycle of delay.
REQ-023 A change of up SHALL take effect on the next counting edge, and SHALL change tco immediately.
REQ-024 With ce=0, clr_n, load_n and count SHALL have no effect and q SHALL hold.

Reset
REQ-025 reset=1 at a clk edge SHALL set q to 0 irrespective of ce, clr_n, load_n, enp and ent.
REQ-026 reset SHALL have priority over every other action, including a load or count on the same edge.
REQ-027 After reset, tco SHALL be ent AND NOT up until q changes.
REQ-028 Deassertion of reset mid-sequence SHALL resume normal operation on the first following edge, with no extra idle cycle.

Configuration
REQ-029 Macro SYNC_COUNTER_MATCH_EN defined SHALL add input cmp (WIDTH bits) and output match (1 bit, registered, reset value 0).
REQ-030 With the macro defined, match SHALL be 1 for the cycle following any ce=1 edge that leaves q equal to cmp; otherwise match SHALL be 0.
REQ-031 With the macro defined, match SHALL clear to 0 on reset and on any ce=1 edge where the new q is not equal to cmp.
REQ-032 Without the macro, cmp and match SHALL not exist and no comparator logic SHALL be built.

Verification
REQ-033 Bench SHALL cover free count: WIDTH=4, MODULUS=10, up=1, enp=ent=ce=1, 12 edges from q=0 -> q runs 1..9,0,1,2; tco=1 only while q=9.
REQ-034 Bench SHALL cover down wrap: MODULUS=10, q=1, up=0, 2 counting edges -> q=0 then q=9; tco=1 only while q=0.
REQ-035 Bench SHALL cover load clamp and priority: p=13 with load_n=0 -> q=9; the same edge with clr_n=0 -> q=0; reset=1 together with load_n=0 -> q=0.
REQ-036 Bench SHALL cover gating: ce=0 with load_n=0 and p=5 -> q unchanged; ent=0 with q=9 and up=1 -> tco=0 and q holds.
REQ-037 Bench SHALL cover a cascade: two WIDTH=4, MODULUS=16 stages, low stage tco driving high stage ent, 256 edges from 0 -> combined count returns to 0x00 and passes 0x0F->0x10 on a single edge.
REQ-038 Bench SHALL cover the match option: SYNC_COUNTER_MATCH_EN defined, cmp=6, counting up from 0 -> match=1 for exactly one cycle after q becomes 6; reset=1 -> match=0.
